instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch-stage initiator for the word-addressable instruction memory. Owns the program counter and presents a word address to the memory every cycle. Absorbs the memory's one-cycle synchronous read latency and delivers an in-order instruction/PC/valid triple to the decode stage. Supports decode back-pressure (stall) and branch redirect without losing or duplicating instructions.

## Interface
- RESET_PC, 32'h0: word address fetched first after reset
- NOP_WORD, 32'h0: value driven on if_instr whenever if_valid is 0 after reset or flush
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  decode cannot accept if_* this cycle; if_* must hold
- branch_taken  in  1  redirect request from a later stage, sampled at posedge
- branch_target  in  32  word address to fetch after redirect
- mem_addr  out  32  word address to instruction memory; memory latches memory[mem_addr] at posedge
- mem_data  in  32  memory read data; valid the cycle after the address was sampled
- if_instr  out  32  fetched instruction (registered)
- if_pc  out  32  word address of if_instr (registered)
- if_valid  out  1  if_instr/if_pc carry a real instruction

## Operation
- Registers: fetch_pc, req_pc, req_valid (word in flight on mem_data), hold_instr/hold_pc/hold_valid (one-entry skid), if_*, state.
- mem_addr = fetch_pc, combinational from the register.
- States:
  - FILL: no valid word in flight; entered after reset or redirect.
  - RUN: streaming.
  - STALL: stall asserted; fetch frozen.
- Each posedge, priority rst > branch_taken > stall > normal.
- rst:
  - fetch_pc=RESET_PC, req_pc=0, req_valid=0, hold_valid=0.
  - if_instr=NOP_WORD, if_pc=0, if_valid=0, state=FILL.
- branch_taken (wins over stall):
  - fetch_pc=branch_target, req_valid=0, hold_valid=0, if_valid=0, if_instr=NOP_WORD.
  - state=FILL. The in-flight word and the current if_* word are discarded.
- stall:
  - if_* hold; fetch_pc holds.
  - If req_valid and !hold_valid: hold <= {mem_data, req_pc, 1}.
  - req_valid=0, so the word the memory reads this edge is ignored and refetched later. state=STALL.
- Normal (no stall):
  - If hold_valid: if_* <= hold, if_valid=1, hold_valid=0.
  - Else: if_instr <= req_valid ? mem_data : NOP_WORD, if_pc <= req_pc, if_valid <= req_valid.
  - req_pc <= fetch_pc, req_valid <= 1, fetch_pc <= fetch_pc + 1. state=RUN.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFF + 1 = 0. No range check against memory depth.
- Ordering invariant: the sequence of if_pc values accepted (if_valid & !stall) equals program order. No gaps, no repeats except across redirect.

## Timing
- Reset release: mem_addr=RESET_PC in cycle 0. First if_valid=1 in cycle 2 with if_pc=RESET_PC.
- Throughput: one instruction per cycle when stall=0.
- Latency: address presented in cycle t appears on if_* in cycle t+2.
- Redirect sampled at edge ending cycle t:
  - mem_addr=target in cycle t+1.
  - if_valid=0 in cycles t+1 and t+2.
  - Target instruction on if_* in cycle t+3 (two bubbles).
- Stall:
  - In any cycle it freezes if_* at that cycle's edge.
  - On the first cycle with stall=0, if_* takes the buffered word.
  - The next word follows in the following cycle, so there is no bubble after stall release if the hold buffer was filled.
- Stall held N cycles: memory reads during the stall are discarded. hold is written only once.
- Stall asserted while state=FILL: hold stays empty; if_valid stays 0.
- rst mid-stall or mid-redirect: all state cleared as above on that edge.

## Test plan
- Reset, memory preloaded with words 0..5 = 32'h813002, 32'h834001 ×5, stall=0 -> if_valid rises in cycle 2. if_pc 0,1,2,3,4,5 on consecutive cycles; if_instr matches; mem_addr increments every cycle.
- Stall high for 3 cycles while if_pc=1 -> if_pc/if_instr hold at 1/32'h834001 for 3 cycles. Then 2,3,4 back-to-back with no bubble and no duplicate.
- branch_taken with branch_target=0 while if_pc=3 -> if_valid=0 for 2 cycles, then if_pc=0, if_instr=32'h813002.
- branch_taken and stall in the same cycle -> redirect wins; if_valid=0 next cycle; hold buffer emptied; target arrives in cycle t+3.
- Stall asserted the cycle after a redirect (state FILL) for 2 cycles -> if_valid stays 0; after release, target instruction appears exactly once.
- fetch_pc driven to 32'hFFFFFFFF via redirect -> if_pc sequence FFFFFFFF, 00000000. rst asserted mid-stream -> next cycle if_valid=0, if_instr=NOP_WORD, mem_addr=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage for a word-addressable instruction memory with a one-cycle
// synchronous read. Owns the program counter, drives a word address every
// cycle and hands an in-order {instr, pc, valid} triple to decode.
//
// Handshake: if_valid is the valid, !stall is the ready. A word transfers to
// decode on a cycle where if_valid && !stall. While stall is high the if_*
// outputs are frozen. branch_taken outranks stall and discards both the
// word on if_* and the word in flight.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   stall           decode cannot accept if_* this cycle
//   branch_taken    redirect request, sampled at posedge
//   branch_target   word address to fetch after a redirect
//   mem_addr        word address to memory (combinational from fetch_pc)
//   mem_data        memory read data, valid the cycle after mem_addr
//   if_instr        registered instruction to decode (NOP_WORD when invalid)
//   if_pc           registered word address of if_instr
//   if_valid        if_instr/if_pc carry a real instruction
//   dbg_state       current FSM state (0 FILL, 1 RUN, 2 STALL)
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] NOP_WORD = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic        req_valid;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        hold_valid;

    // Control strobes decoded from state and inputs.
    logic        flush;
    logic        freeze;
    logic        capture_hold;

    assign mem_addr  = fetch_pc;
    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: branch_taken > stall > normal
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            state_d = S_FILL;
        end else if (stall) begin
            state_d = S_STALL;
        end else begin
            state_d = S_RUN;
        end
    end

    // ------------------------------------------------------------------
    // Output/control logic
    // ------------------------------------------------------------------
    // Only in RUN is a live word guaranteed on mem_data: FILL has nothing
    // in flight yet and STALL already dropped req_valid on its first edge,
    // so the skid buffer is written at most once per stall episode.
    always_comb begin
        flush        = 1'b0;
        freeze       = 1'b0;
        capture_hold = 1'b0;
        if (branch_taken) begin
            flush = 1'b1;
        end else if (stall) begin
            freeze       = 1'b1;
            capture_hold = (state_q == S_RUN) && req_valid && !hold_valid;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            req_pc     <= 32'h0;
            req_valid  <= 1'b0;
            hold_instr <= NOP_WORD;
            hold_pc    <= 32'h0;
            hold_valid <= 1'b0;
            if_instr   <= NOP_WORD;
            if_pc      <= 32'h0;
            if_valid   <= 1'b0;
        end else if (flush) begin
            fetch_pc   <= branch_target;
            req_valid  <= 1'b0;
            hold_valid <= 1'b0;
            if_valid   <= 1'b0;
            if_instr   <= NOP_WORD;
        end else if (freeze) begin
            if (capture_hold) begin
                hold_instr <= mem_data;
                hold_pc    <= req_pc;
                hold_valid <= 1'b1;
            end
            // The word the memory reads at this edge is dropped; fetch_pc
            // is frozen, so the same address is requested again on release.
            req_valid <= 1'b0;
        end else begin
            if (hold_valid) begin
                if_instr   <= hold_instr;
                if_pc      <= hold_pc;
                if_valid   <= 1'b1;
                hold_valid <= 1'b0;
            end else begin
                if_instr <= req_valid ? mem_data : NOP_WORD;
                if_pc    <= req_pc;
                if_valid <= req_valid;
            end
            req_pc    <= fetch_pc;
            req_valid <= 1'b1;
            fetch_pc  <= fetch_pc + 32'd1;   // wraps modulo 2^32
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. A small behavioural memory returns
// memory[mem_addr[3:0]] one cycle after the address. Outputs are sampled on
// the falling edge; inputs are driven right after sampling. Each table row
// holds the inputs for one cycle and the outputs expected during that cycle.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] NOP  = 32'h0;
    localparam logic [31:0] M0   = 32'h0081_3002;
    localparam logic [31:0] M1   = 32'h0083_4001;
    localparam logic [31:0] MF   = 32'hA000_000F;
    localparam logic [31:0] WRAP = 32'hFFFF_FFFF;
    localparam int          NV   = 25;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] mem_addr;
    logic [31:0] mem_data = 32'h0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC (32'h0),
        .NOP_WORD (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .dbg_state     (dbg_state)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [0:15];

    always @(posedge clk) mem_data <= mem[mem_addr[3:0]];

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic s, input logic b, input logic [31:0] t);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " valid"}, {31'h0, if_valid}, 32'h0);
        check({tag, " instr"}, if_instr, NOP);
        check({tag, " pc"},    if_pc, 32'h0);
        check({tag, " addr"},  mem_addr, 32'h0);
        check({tag, " state"}, {30'h0, dbg_state}, 32'h0);
    endtask

    // Waits (bounded) for the first valid word after reset release and
    // checks it lands exactly two cycles after release with pc 0.
    task automatic expect_first_valid(input string tag);
        int cyc;
        cyc = 0;
        while (!if_valid && cyc < 8) begin
            next_cycle();
            cyc++;
        end
        check({tag, " first-valid cycle"}, cyc, 32'd2);
        check({tag, " first pc"}, if_pc, 32'h0);
        check({tag, " first instr"}, if_instr, M0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        s;
        logic        b;
        logic [31:0] tgt;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs [NV];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = M0;
        for (int i = 1; i < 6; i++) mem[i] = M1;

        //          s  b  tgt    addr   v  pc     instr
        vecs[0]  = '{0, 0, 32'h0, 32'h0, 0, 32'h0, NOP};
        vecs[1]  = '{0, 0, 32'h0, 32'h1, 0, 32'h0, NOP};
        vecs[2]  = '{0, 0, 32'h0, 32'h2, 1, 32'h0, M0};
        vecs[3]  = '{1, 0, 32'h0, 32'h3, 1, 32'h1, M1};
        vecs[4]  = '{1, 0, 32'h0, 32'h3, 1, 32'h1, M1};
        vecs[5]  = '{1, 0, 32'h0, 32'h3, 1, 32'h1, M1};
        vecs[6]  = '{0, 0, 32'h0, 32'h3, 1, 32'h1, M1};
        vecs[7]  = '{0, 0, 32'h0, 32'h4, 1, 32'h2, M1};
        vecs[8]  = '{0, 1, 32'h0, 32'h5, 1, 32'h3, M1};   // redirect to 0
        vecs[9]  = '{0, 0, 32'h0, 32'h0, 0, 32'h0, NOP};
        vecs[10] = '{0, 0, 32'h0, 32'h1, 0, 32'h0, NOP};
        vecs[11] = '{1, 1, 32'h4, 32'h2, 1, 32'h0, M0};   // redirect + stall
        vecs[12] = '{0, 0, 32'h0, 32'h4, 0, 32'h0, NOP};
        vecs[13] = '{0, 0, 32'h0, 32'h5, 0, 32'h0, NOP};
        vecs[14] = '{0, 1, WRAP,  32'h6, 1, 32'h4, M1};   // redirect to top
        vecs[15] = '{1, 0, 32'h0, WRAP,  0, 32'h0, NOP};  // stall in FILL
        vecs[16] = '{1, 0, 32'h0, WRAP,  0, 32'h0, NOP};
        vecs[17] = '{0, 0, 32'h0, WRAP,  0, 32'h0, NOP};
        vecs[18] = '{0, 0, 32'h0, 32'h0, 0, 32'h0, NOP};
        vecs[19] = '{0, 0, 32'h0, 32'h1, 1, WRAP,  MF};
        vecs[20] = '{0, 0, 32'h0, 32'h2, 1, 32'h0, M0};
        vecs[21] = '{1, 0, 32'h0, 32'h3, 1, 32'h1, M1};   // single-cycle stall
        vecs[22] = '{0, 0, 32'h0, 32'h3, 1, 32'h1, M1};
        vecs[23] = '{0, 0, 32'h0, 32'h4, 1, 32'h2, M1};
        vecs[24] = '{0, 0, 32'h0, 32'h5, 1, 32'h3, M1};

        // Program-order PCs decode should accept (valid, no stall, no redirect).
        exp_q = '{32'h0, 32'h1, 32'h2, WRAP, 32'h0, 32'h1, 32'h2, 32'h3};

        // Reset held for two edges, then checked while still asserted.
        drive(0, 0, 32'h0);
        repeat (2) @(posedge clk);
        next_cycle();
        check_cleared("reset");
        rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            check($sformatf("c%0d addr", i), mem_addr, vecs[i].e_addr);
            check($sformatf("c%0d valid", i), {31'h0, if_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("c%0d instr", i), if_instr, vecs[i].e_instr);
            if (vecs[i].e_valid)
                check($sformatf("c%0d pc", i), if_pc, vecs[i].e_pc);
            if (if_valid && !vecs[i].s && !vecs[i].b) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL c%0d order: got pc %h expected none", i, if_pc);
                end else begin
                    check($sformatf("c%0d order", i), if_pc, exp_q.pop_front());
                end
            end
            if (i == 4) check("c4 state", {30'h0, dbg_state}, 32'd2);
            if (i == 7) check("c7 state", {30'h0, dbg_state}, 32'd1);
            drive(vecs[i].s, vecs[i].b, vecs[i].tgt);
            next_cycle();
        end
        check("order queue drained", exp_q.size(), 32'd0);

        // ---------------- reset mid-stream ----------------
        drive(0, 0, 32'h0);
        rst = 1'b1;
        next_cycle();
        check_cleared("rst mid-stream");
        rst = 1'b0;
        expect_first_valid("after rst1");

        // ---------------- reset mid-stall (hold full) ----------------
        stall = 1'b1;
        next_cycle();
        check("stall before rst pc", if_pc, 32'h0);
        rst = 1'b1;                      // stall still high
        next_cycle();
        check_cleared("rst mid-stall");
        rst   = 1'b0;
        stall = 1'b0;
        expect_first_valid("after rst2");
        next_cycle();
        check("after rst2 pc1", if_pc, 32'h1);
        next_cycle();
        check("after rst2 pc2", if_pc, 32'h2);

        // ---------------- redirect while hold buffer is full ----------------
        drive(1, 0, 32'h0);
        next_cycle();
        check("held pc2", if_pc, 32'h2);
        check("held state", {30'h0, dbg_state}, 32'd2);
        drive(1, 1, 32'h6);
        next_cycle();
        drive(0, 0, 32'h0);
        check("redir t+1 valid", {31'h0, if_valid}, 32'h0);
        check("redir t+1 addr", mem_addr, 32'h6);
        next_cycle();
        check("redir t+2 valid", {31'h0, if_valid}, 32'h0);
        check("redir t+2 instr", if_instr, NOP);
        next_cycle();
        check("redir t+3 pc", if_pc, 32'h6);
        check("redir t+3 instr", if_instr, 32'hA000_0006);
        check("redir t+3 valid", {31'h0, if_valid}, 32'h1);
        next_cycle();
        check("redir t+4 pc", if_pc, 32'h7);
        check("redir t+4 instr", if_instr, 32'hA000_0007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
